// File: rtl/vrm_precharge_scheduler_pkg.sv
// Shared AIPP definitions for the pre-charge scheduling path.
// Contents: opcode constant, command field widths, the packed command
// type carried through the command FIFO, FSM state encoding and the
// setpoint clamp helper.
package vrm_precharge_scheduler_pkg;

    localparam logic [7:0]  OPCODE_PRECHARGE = 8'h10;

    localparam int unsigned DELAY_W = 32;
    localparam int unsigned VOLT_W  = 32;
    localparam int unsigned SETPT_W = 16;
    localparam int unsigned CMD_W   = DELAY_W + VOLT_W;

    typedef struct packed {
        logic [DELAY_W-1:0] delay_us;
        logic [VOLT_W-1:0]  voltage_mv;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_REQ  = 2'd2
    } state_t;

    function automatic logic [VOLT_W-1:0] clamp_mv(
        input logic [VOLT_W-1:0] v,
        input logic [VOLT_W-1:0] lo,
        input logic [VOLT_W-1:0] hi
    );
        logic [VOLT_W-1:0] r;
        r = v;
        if (v < lo) r = lo;
        else if (v > hi) r = hi;
        return r;
    endfunction

endpackage

// File: rtl/vrm_precharge_scheduler_cmd_fifo.sv
// aipp_cmd_fifo: synchronous FIFO for decoded pre-charge commands.
// Ports:
//   aclk, aresetn      clock, async active-low reset (discards contents)
//   push, push_data    write request/data; accepted when not full, or
//                      when full and a pop happens on the same edge
//   pop, pop_data      read request; pop_data shows the head entry
//   full, empty, count occupancy status
module aipp_cmd_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    always_comb begin
        full     = (count == CW'(DEPTH));
        empty    = (count == '0);
        rd_en    = pop && !empty;
        wr_en    = push && (!full || rd_en);
        pop_data = mem[rd_ptr];
    end

    // When full, wr_ptr == rd_ptr: the head is read before the edge, so
    // overwriting that slot on a simultaneous push+pop is safe.
    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vrm_precharge_scheduler.sv
// vrm_precharge_scheduler: queues pre-charge commands from the AIPP
// header parser, waits each command's delay (measured from pop), then
// presents the clamped voltage setpoint to the VRM over req/ack.
// Ports:
//   aclk, aresetn       clock, async active-low reset
//   cmd_valid           one-cycle command strobe (no backpressure)
//   cmd_delay_us        delay before applying setpoint, microseconds
//   cmd_voltage_mv      requested voltage, mV
//   cmd_overflow        pulse: command dropped, FIFO full
//   cmd_clamped         pulse: popped command's voltage was clamped
//   vrm_req, vrm_ack    setpoint handshake
//   vrm_setpoint_mv     setpoint, stable while vrm_req is high
//   apply_done          pulse: handshake accepted
//   err_timeout         pulse: no ack within ACK_TIMEOUT cycles
//   busy                FSM active or commands queued
//   fifo_count          FIFO occupancy
module vrm_precharge_scheduler
    import vrm_precharge_scheduler_pkg::*;
#(
    parameter int unsigned CLK_MHZ     = 1000,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned VMIN_MV     = 500,
    parameter int unsigned VMAX_MV     = 1200,
    parameter int unsigned ACK_TIMEOUT = 1024
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          cmd_valid,
    input  logic [DELAY_W-1:0]            cmd_delay_us,
    input  logic [VOLT_W-1:0]             cmd_voltage_mv,
    output logic                          cmd_overflow,
    output logic                          cmd_clamped,
    output logic                          vrm_req,
    output logic [SETPT_W-1:0]            vrm_setpoint_mv,
    input  logic                          vrm_ack,
    output logic                          apply_done,
    output logic                          err_timeout,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int unsigned PRE_W = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
    localparam int unsigned TO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [PRE_W-1:0] PRE_RELOAD = PRE_W'(CLK_MHZ - 1);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(ACK_TIMEOUT - 1);

    state_t             state;
    logic [DELAY_W-1:0] us_cnt;
    logic [PRE_W-1:0]   pre_cnt;
    logic [TO_W-1:0]    to_cnt;

    cmd_t               cmd_in;
    cmd_t               head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic [VOLT_W-1:0]  clamped_v;

    always_comb begin
        cmd_in    = '{delay_us: cmd_delay_us, voltage_mv: cmd_voltage_mv};
        pop       = (state == ST_IDLE) && !fifo_empty;
        clamped_v = clamp_mv(head.voltage_mv, VOLT_W'(VMIN_MV), VOLT_W'(VMAX_MV));
        busy      = (state != ST_IDLE) || !fifo_empty;
    end

    aipp_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (cmd_valid),
        .push_data (cmd_in),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state           <= ST_IDLE;
            us_cnt          <= '0;
            pre_cnt         <= '0;
            to_cnt          <= '0;
            vrm_req         <= 1'b0;
            vrm_setpoint_mv <= '0;
            apply_done      <= 1'b0;
            err_timeout     <= 1'b0;
            cmd_clamped     <= 1'b0;
            cmd_overflow    <= 1'b0;
        end else begin
            apply_done   <= 1'b0;
            err_timeout  <= 1'b0;
            cmd_clamped  <= 1'b0;
            cmd_overflow <= cmd_valid && fifo_full && !pop;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state           <= ST_WAIT;
                        us_cnt          <= head.delay_us;
                        pre_cnt         <= PRE_RELOAD;
                        vrm_setpoint_mv <= clamped_v[SETPT_W-1:0];
                        cmd_clamped     <= (clamped_v != head.voltage_mv);
                    end
                end
                ST_WAIT: begin
                    if (us_cnt == '0) begin
                        state   <= ST_REQ;
                        vrm_req <= 1'b1;
                        to_cnt  <= '0;
                    end else if (pre_cnt == '0) begin
                        pre_cnt <= PRE_RELOAD;
                        us_cnt  <= us_cnt - DELAY_W'(1);
                    end else begin
                        pre_cnt <= pre_cnt - PRE_W'(1);
                    end
                end
                ST_REQ: begin
                    // Ack takes priority so an ack on the last cycle succeeds.
                    if (vrm_ack) begin
                        state      <= ST_IDLE;
                        vrm_req    <= 1'b0;
                        apply_done <= 1'b1;
                    end else if (to_cnt == TO_LAST) begin
                        state       <= ST_IDLE;
                        vrm_req     <= 1'b0;
                        err_timeout <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/vrm_precharge_scheduler.md
Name: vrm_precharge_scheduler

Overview:
Downstream stage of the AIPP header parser. It takes each decoded pre-charge command (delay_us, voltage_mv), sent as a one-cycle valid pulse, and places it in a small command FIFO. For each command it waits the requested delay in microseconds, then drives the clamped voltage setpoint to the VRM controller over a req/ack handshake. The parser output has no backpressure, so this block must absorb or explicitly drop every pulse.

Parameters:
CLK_MHZ, 1000, aclk cycles per microsecond (prescaler reload = CLK_MHZ-1); must be >=1
FIFO_DEPTH, 4, command FIFO entries; power of two, >=2
VMIN_MV, 500, lower setpoint clamp in mV
VMAX_MV, 1200, upper setpoint clamp in mV; VMIN_MV <= VMAX_MV < 65536
ACK_TIMEOUT, 1024, max cycles vrm_req stays high awaiting vrm_ack

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous, active-low
cmd_valid  in  1  one-cycle command strobe (parser valid_out)
cmd_delay_us  in  32  delay before setpoint is applied, in microseconds
cmd_voltage_mv  in  32  requested voltage in mV
cmd_overflow  out  1  one-cycle pulse: command dropped because FIFO full
cmd_clamped  out  1  one-cycle pulse: a popped command's voltage was clamped
vrm_req  out  1  setpoint request to VRM
vrm_setpoint_mv  out  16  setpoint; stable while vrm_req=1
vrm_ack  in  1  VRM accepted setpoint
apply_done  out  1  one-cycle pulse on accepted handshake
err_timeout  out  1  one-cycle pulse on ack timeout
busy  out  1  state != IDLE or FIFO non-empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset (async assert, sync release): all outputs 0, fifo_count=0, FIFO contents discarded, FSM=IDLE. vrm_req drops immediately on assertion, even mid-handshake or mid-countdown.
- Push: cmd_valid=1 and FIFO not full, or full with a pop on the same edge, writes {delay, voltage}. Otherwise the command is dropped and cmd_overflow pulses on the next cycle.
- Simultaneous push+pop: fifo_count unchanged. The pushed entry is never the one popped on the same edge, so there is no bypass. A command pushed into an empty FIFO is popped at the earliest one edge later.
- FSM states: IDLE, WAIT, REQ.
- IDLE: if FIFO non-empty, pop at the edge and go to WAIT.
  - Load us_cnt=delay and pre_cnt=CLK_MHZ-1.
  - Load setpoint = clamp(voltage, VMIN_MV, VMAX_MV), truncated to 16 bits after the clamp.
  - cmd_clamped pulses next cycle if the clamp changed the value.
- WAIT:
  - If us_cnt==0: go to REQ; vrm_req=1 registered.
  - Else if pre_cnt==0: pre_cnt=CLK_MHZ-1 and us_cnt decrements.
  - Else pre_cnt decrements.
  - Result: vrm_req rises exactly D*CLK_MHZ+1 edges after the pop edge (D=0 gives 1 edge).
  - us_cnt is full 32-bit with no saturation.
- REQ: vrm_req=1, setpoint held stable; a timeout counter starts at 0.
  - vrm_ack=1 sampled: vrm_req=0 and apply_done=1 next cycle; go to IDLE.
  - Counter reaches ACK_TIMEOUT-1 without ack: vrm_req=0 and err_timeout=1; command is discarded; go to IDLE.
  - Ack on the timeout cycle counts as success.
- vrm_ack outside REQ is ignored.
- Back-to-back: after apply_done, IDLE pops the next entry on the following edge, so there is a one-cycle gap minimum between vrm_req pulses.
- vrm_setpoint_mv holds its last value after the handshake; 0 after reset.
- Commands are strictly in order. Delays are measured from pop, not from arrival.

Decomposition:
- Shared AIPP package/header holds:
  - OPCODE_PRECHARGE=8'h10
  - field widths (DELAY_W=32, VOLT_W=32, SETPT_W=16)
  - packed command type {delay_us, voltage_mv} (64 bits)
  - FSM state encodings
- One sub-module: aipp_cmd_fifo, a synchronous FIFO with width 64 and depth FIFO_DEPTH, exposing full/empty/count. Clamp, prescaler and FSM stay in the top level.

Test Plan:
- Bench uses CLK_MHZ=4, ACK_TIMEOUT=16.
- Single command, delay=3, voltage=900, ack on the first REQ cycle -> vrm_req rises 13 edges after the pop, setpoint=900, apply_done one pulse, busy falls.
- delay=0, voltage=1500 -> vrm_req 1 edge after pop, setpoint=1200, cmd_clamped pulse. Separately, voltage=100 -> setpoint=500.
- 6 strobes on consecutive cycles, delay=0, ack held low for 5 cycles each -> first 5 accepted (4 stored plus 1 from the same-edge pop), cmd_overflow pulses once, setpoints applied in push order.
- vrm_ack never asserted -> vrm_req high for exactly 16 cycles, err_timeout pulse, next queued command proceeds.
- aresetn asserted mid-WAIT and mid-REQ with 3 queued -> vrm_req=0 immediately, fifo_count=0, no apply_done after release.
- Push on the same cycle as the pop with the FIFO full -> no overflow, fifo_count stays 4.
